// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end with stall, redirect/flush and a small decoupling
// buffer. The PC register addresses a combinational instruction memory; each
// accepted fetch queues a {pc, instr} pair. Decode drains the queue with a
// valid/ready handshake. A redirect from later pipeline stages flushes the
// queue and restarts fetch at a word-aligned target.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   imem_addr_o    fetch address (the PC register)
//   imem_rdata_i   instruction word for imem_addr_o
//   imem_valid_i   imem_rdata_i is usable this cycle
//   redirect_i     flush the buffer and load redirect_pc_i
//   redirect_pc_i  redirect target (low two bits ignored)
//   valid_o        buffer head holds an entry
//   ready_i        decode accepts the head entry
//   pc_o           PC of the head entry (zero while empty)
//   instr_o        instruction of the head entry (zero while empty)
//   count_o        buffer occupancy
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h0000_0000),
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [XLEN-1:0]               imem_addr_o,
    input  logic [XLEN-1:0]               imem_rdata_i,
    input  logic                          imem_valid_i,
    input  logic                          redirect_i,
    input  logic [XLEN-1:0]               redirect_pc_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [XLEN-1:0]               pc_o,
    output logic [XLEN-1:0]               instr_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  pc_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [XLEN-1:0]  pc_mem_r    [FIFO_DEPTH];
    logic [XLEN-1:0]  instr_mem_r [FIFO_DEPTH];

    logic             push_s;
    logic             pop_s;
    logic             not_empty_s;
    logic [CNT_W-1:0] count_next_s;

    assign not_empty_s = (count_r != CNT_W'(0));

    // Handshake qualification: a redirect suppresses both push and pop; a full
    // buffer refuses a push even when a pop frees a slot in the same cycle.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (redirect_i) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = imem_valid_i && (count_r < CNT_W'(FIFO_DEPTH));
            pop_s  = not_empty_s && ready_i;
        end
    end

    // Occupancy update for the non-redirect case.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // PC, pointers and occupancy; redirect takes priority over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r     <= RESET_PC;
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (redirect_i) begin
            pc_r     <= {redirect_pc_i[XLEN-1:2], 2'b00};
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                pc_r     <= pc_r + XLEN'(4);
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Buffer storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= pc_r;
            instr_mem_r[wr_ptr_r] <= imem_rdata_i;
        end
    end

    // Head read, forced to zero while empty so reset presents clean outputs.
    always_comb begin
        pc_o    = XLEN'(0);
        instr_o = XLEN'(0);
        if (not_empty_s) begin
            pc_o    = pc_mem_r[rd_ptr_r];
            instr_o = instr_mem_r[rd_ptr_r];
        end else begin
            pc_o    = XLEN'(0);
            instr_o = XLEN'(0);
        end
    end

    assign imem_addr_o = pc_r;
    assign valid_o     = not_empty_s;
    assign count_o     = count_r;

endmodule
